regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port (Aw/Dw/WrEn) between two writeback sources:
//  req0 = ALU result, req1 = load/link result. Program order is req0 before req1.

---
 rtl/regfile_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the register file's single write port, with
// per-source holding slots and RAW hazard flags. Define REGARB_FWD_EN for forwarding outputs.
module regfile_write_arbiter #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_data,
    output logic [AW-1:0]   Aw,
    output logic [DW-1:0]   Dw,
    output logic            WrEn,
    input  logic [AW-1:0]   Aa,
    input  logic [AW-1:0]   Ab,
    output logic            hazard_a,
    output logic            hazard_b,
    output logic [CNTW-1:0] wr_count
`ifdef REGARB_FWD_EN
    ,
    output logic [DW-1:0]   fwd_a_data,
    output logic [DW-1:0]   fwd_b_data,
    output logic            fwd_a_hit,
    output logic            fwd_b_hit
`endif
);

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         grant;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_data;
    logic [1:0]         slot_full_reg;
    logic [1:0][AW-1:0] slot_addr_reg;
    logic [1:0][DW-1:0] slot_data_reg;
    logic               rr_reg;
    logic [1:0][AW-1:0] rd_addr;
    logic [1:0]         rd_match;
`ifdef REGARB_FWD_EN
    logic [1:0][DW-1:0] rd_fwd;
`endif

    assign req_valid = {req1_valid, req0_valid};
    assign req_addr  = {req1_addr, req0_addr};
    assign req_data  = {req1_data, req0_data};
    assign rd_addr   = {Ab, Aa};

    // Equal destinations must retire in program order, so slot0 wins regardless of rr.
    always_comb begin
        grant = 2'b00;
        if (&slot_full_reg) begin
            if ((slot_addr_reg[0] == slot_addr_reg[1]) || !rr_reg) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else begin
            grant = slot_full_reg;
        end
    end

    assign req_ready  = ~slot_full_reg | grant;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // Writes to r0 are acknowledged but never occupy a slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_full_reg <= '0;
            slot_addr_reg <= '0;
            slot_data_reg <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    slot_full_reg[i] <= (req_addr[i] != '0);
                    slot_addr_reg[i] <= req_addr[i];
                    slot_data_reg[i] <= req_data[i];
                end else if (grant[i]) begin
                    slot_full_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Aw       <= '0;
            Dw       <= '0;
            WrEn     <= 1'b0;
            rr_reg   <= 1'b0;
            wr_count <= '0;
        end else begin
            if (|grant) begin
                WrEn <= 1'b1;
                Aw   <= grant[0] ? slot_addr_reg[0] : slot_addr_reg[1];
                Dw   <= grant[0] ? slot_data_reg[0] : slot_data_reg[1];
            end else begin
                WrEn <= 1'b0;
            end
            if (&slot_full_reg) begin
                rr_reg <= grant[0];
            end
            if (WrEn) begin
                wr_count <= wr_count + CNTW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic hit0;
            logic hit1;
            logic hitw;
            assign hit0 = slot_full_reg[0] && (slot_addr_reg[0] == rd_addr[gi]);
            assign hit1 = slot_full_reg[1] && (slot_addr_reg[1] == rd_addr[gi]);
            assign hitw = WrEn && (Aw == rd_addr[gi]);
            assign rd_match[gi] = (rd_addr[gi] != '0) && (hit0 || hit1 || hitw);
`ifdef REGARB_FWD_EN
            // Youngest pending value first: slot1 holds the later-ordered write.
            assign rd_fwd[gi] = hit1 ? slot_data_reg[1] :
                                hit0 ? slot_data_reg[0] : Dw;
`endif
        end
    endgenerate

`ifdef REGARB_FWD_EN
    assign hazard_a   = 1'b0;
    assign hazard_b   = 1'b0;
    assign fwd_a_hit  = rd_match[0];
    assign fwd_b_hit  = rd_match[1];
    assign fwd_a_data = rd_fwd[0];
    assign fwd_b_data = rd_fwd[1];
`else
    assign hazard_a = rd_match[0];
    assign hazard_b = rd_match[1];
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle comparison against a behavioural model,
// plus directed scenarios with literal expectations on the retired write sequence.
module tb_regfile_write_arbiter;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CNTW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [AW-1:0]   req0_addr = '0, req1_addr = '0;
    logic [DW-1:0]   req0_data = '0, req1_data = '0;
    logic [AW-1:0]   Aw;
    logic [DW-1:0]   Dw;
    logic            WrEn;
    logic [AW-1:0]   Aa = '0, Ab = '0;
    logic            hazard_a, hazard_b;
    logic [CNTW-1:0] wr_count;

    regfile_write_arbiter #(.AW(AW), .DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .Aw(Aw), .Dw(Dw), .WrEn(WrEn), .Aa(Aa), .Ab(Ab),
        .hazard_a(hazard_a), .hazard_b(hazard_b), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: what each source is still holding, which source wins a tie,
    // what the register file is about to write, and how many writes have retired.
    bit              m_full [2];
    wr_t             m_slot [2];
    bit              m_next;
    bit              m_wren;
    wr_t             m_w;
    logic [CNTW-1:0] m_cnt;

    function automatic int pick();
        if (m_full[0] && m_full[1]) begin
            if (m_slot[0].a == m_slot[1].a) return 0;
            return int'(m_next);
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic bit m_hz(logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        return (m_full[0] && m_slot[0].a == a) || (m_full[1] && m_slot[1].a == a) ||
               (m_wren && m_w.a == a);
    endfunction

    always @(posedge clk or posedge reset) begin : model_upd
        int  g;
        bit  both;
        bit  r0, r1;
        bit  nf [2];
        wr_t ns [2];
        bit  nnext;
        bit  nwren;
        wr_t nw;
        if (reset) begin
            m_full <= '{1'b0, 1'b0};
            m_next <= 1'b0;
            m_wren <= 1'b0;
            m_w    <= '0;
            m_cnt  <= '0;
        end else begin
            g     = pick();
            both  = m_full[0] && m_full[1];
            r0    = !m_full[0] || g == 0;
            r1    = !m_full[1] || g == 1;
            nf    = m_full;
            ns    = m_slot;
            nnext = m_next;
            nwren = 1'b0;
            nw    = m_w;
            if (g >= 0) begin
                nwren = 1'b1;
                nw    = m_slot[g];
                nf[g] = 1'b0;
                if (both) nnext = (g == 0);
            end
            if (req0_valid && r0 && req0_addr != '0) begin
                nf[0] = 1'b1;
                ns[0] = '{req0_addr, req0_data};
            end
            if (req1_valid && r1 && req1_addr != '0) begin
                nf[1] = 1'b1;
                ns[1] = '{req1_addr, req1_data};
            end
            m_full <= nf;
            m_slot <= ns;
            m_next <= nnext;
            m_wren <= nwren;
            m_w    <= nw;
            if (m_wren) m_cnt <= m_cnt + CNTW'(1);
        end
    end

    wr_t wlog [$];
    bit  log_en = 1'b1;

    always @(negedge clk) begin : compare
        int g;
        g = pick();
        chk("wren", WrEn, m_wren);
        chk("aw", Aw, m_w.a);
        chk("dw", Dw, m_w.d);
        chk("wr_count", wr_count, m_cnt);
        chk("ready0", req0_ready, !m_full[0] || g == 0);
        chk("ready1", req1_ready, !m_full[1] || g == 1);
        chk("hazard_a", hazard_a, m_hz(Aa));
        chk("hazard_b", hazard_b, m_hz(Ab));
        if (WrEn && log_en) wlog.push_back('{Aw, Dw});
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present requests and hold each until accepted; n0/n1 report cycles spent.
    task automatic send(input bit v0, input wr_t p0, input bit v1, input wr_t p1,
                        output int n0, output int n1);
        bit pend0, pend1, a0, a1;
        int guard;
        pend0 = v0; pend1 = v1; n0 = 0; n1 = 0; guard = 0;
        while ((pend0 || pend1) && guard < 20) begin
            req0_valid = pend0; req0_addr = p0.a; req0_data = p0.d;
            req1_valid = pend1; req1_addr = p1.a; req1_data = p1.d;
            @(negedge clk);
            a0 = pend0 && req0_ready;
            a1 = pend1 && req1_ready;
            @(posedge clk);
            #1;
            if (pend0) n0++;
            if (pend1) n1++;
            if (a0) pend0 = 1'b0;
            if (a1) pend1 = 1'b0;
            guard++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (pend0 || pend1) chk("send_timeout", 1, 0);
    endtask

    task automatic chk_wr(string nm, int idx, logic [AW-1:0] a, logic [DW-1:0] d);
        if (idx >= wlog.size()) begin
            chk({nm, "_missing"}, wlog.size(), idx + 1);
        end else begin
            chk({nm, "_addr"}, wlog[idx].a, a);
            chk({nm, "_data"}, wlog[idx].d, d);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n0, n1;
        logic [CNTW-1:0] cnt_before;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren", WrEn, 0);
        chk("rst_aw", Aw, 0);
        chk("rst_dw", Dw, 0);
        chk("rst_count", wr_count, 0);
        chk("rst_ready0", req0_ready, 1);
        chk("rst_ready1", req1_ready, 1);
        reset = 1'b0;
        idle(1);
        $display("reset released: WrEn=%0d wr_count=%0d", WrEn, wr_count);

        // 1: lone ALU write
        wlog.delete();
        send(1, '{5'd2, 32'd42}, 0, '0, n0, n1);
        chk("t1_accept_cycles", n0, 1);
        chk("t1_wren_early", WrEn, 0);
        idle(1);
        chk("t1_wren", WrEn, 1);
        chk("t1_aw", Aw, 2);
        chk("t1_dw", Dw, 42);
        idle(1);
        chk("t1_count", wr_count, 1);
        chk("t1_wren_drop", WrEn, 0);
        $display("t1: write r%0d=%0d, wr_count=%0d", wlog[0].a, wlog[0].d, wr_count);

        // 2: both sources, back-to-back
        pulse_reset();
        wlog.delete();
        send(1, '{5'd3, 32'd10}, 1, '{5'd4, 32'd20}, n0, n1);
        chk("t2a_cycles0", n0, 1);
        chk("t2a_cycles1", n1, 1);
        send(1, '{5'd5, 32'd30}, 1, '{5'd6, 32'd40}, n0, n1);
        chk("t2b_cycles0", n0, 1);
        chk("t2b_cycles1", n1, 2);
        idle(5);
        chk("t2_nwrites", wlog.size(), 4);
        chk_wr("t2_w0", 0, 3, 10);
        chk_wr("t2_w1", 1, 4, 20);
        chk_wr("t2_w2", 2, 5, 30);
        chk_wr("t2_w3", 3, 6, 40);
        chk("t2_count", wr_count, 4);
        $display("t2: %0d writes retired, wr_count=%0d", wlog.size(), wr_count);

        // 3: same destination from both sources, program order kept
        pulse_reset();
        wlog.delete();
        send(1, '{5'd7, 32'd11}, 1, '{5'd7, 32'd22}, n0, n1);
        idle(4);
        chk("t3_nwrites", wlog.size(), 2);
        chk_wr("t3_w0", 0, 7, 11);
        chk_wr("t3_w1", 1, 7, 22);
        $display("t3: r7 writes in order %0d then %0d", 11, 22);

        // 4: write to r0 is swallowed
        wlog.delete();
        cnt_before = wr_count;
        send(0, '0, 1, '{5'd0, 32'd99}, n0, n1);
        chk("t4_accept_cycles", n1, 1);
        idle(3);
        chk("t4_nwrites", wlog.size(), 0);
        chk("t4_count", wr_count, cnt_before);
        $display("t4: r0 write discarded, wr_count=%0d", wr_count);

        // 5: hazard tracking through slot and write stage
        Aa = 5'd9;
        Ab = 5'd0;
        #1;
        chk("t5_haz_idle", hazard_a, 0);
        send(1, '{5'd9, 32'd55}, 0, '0, n0, n1);
        chk("t5_haz_slot", hazard_a, 1);
        chk("t5_hazb_slot", hazard_b, 0);
        idle(1);
        chk("t5_wren", WrEn, 1);
        chk("t5_haz_wstage", hazard_a, 1);
        chk("t5_hazb_wstage", hazard_b, 0);
        idle(1);
        chk("t5_haz_clear", hazard_a, 0);
        $display("t5: hazard_a cleared after write of r9");
        Aa = '0;

        // 6: asynchronous reset mid-flight, then counter wrap
        pulse_reset();
        send(1, '{5'd8, 32'd1}, 1, '{5'd10, 32'd2}, n0, n1);
        send(1, '{5'd11, 32'd3}, 0, '0, n0, n1);
        chk("t6_wren_before", WrEn, 1);
        Aa = 5'd10;
        #1;
        chk("t6_haz_before", hazard_a, 1);
        wlog.delete();
        reset = 1'b1;
        #1;
        chk("t6_wren_async", WrEn, 0);
        chk("t6_count_async", wr_count, 0);
        chk("t6_haz_async", hazard_a, 0);
        chk("t6_ready0_async", req0_ready, 1);
        chk("t6_ready1_async", req1_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        chk("t6_no_writes", wlog.size(), 0);
        Aa = '0;
        $display("t6: reset flushed pending writes, wr_count=%0d", wr_count);

        log_en = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            req0_valid = 1'b1;
            req0_addr  = AW'((i % 31) + 1);
            req0_data  = DW'(i);
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        idle(3);
        chk("t6_count_max", wr_count, 16'hFFFF);
        $display("t6: after 65535 writes wr_count=%0h", wr_count);
        send(1, '{5'd1, 32'd1}, 0, '0, n0, n1);
        idle(3);
        chk("t6_count_wrap", wr_count, 0);
        $display("t6: one more write, wr_count=%0h", wr_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
